// File: rtl/gf16_share_compress_reg_pkg.sv
// ----------------------------------------------------------------------------
// gf16_share_compress_reg_pkg
//   Shared constants and types for the 4->2 share-compressing register stage
//   that follows the 2->4 share-expanding GF(2^4) multiplier.
//   - SHARE_W   : width of one GF(2^4) element (a nibble)
//   - LANES_DEF : default number of nibble lanes per transfer
//   - share4_t  : the four expanded shares of one transfer
//   - share2_t  : the compressed share pair handed to the next S-box stage
//   - q_op_e    : queue operation of one cycle, encoded as {push, pop}
// ----------------------------------------------------------------------------
package gf16_share_compress_reg_pkg;

   localparam int SHARE_W   = 4;
   localparam int LANES_DEF = 1;

   typedef logic [SHARE_W*LANES_DEF-1:0] share_t;

   typedef struct packed {
      share_t q0;
      share_t q1;
      share_t q2;
      share_t q3;
   } share4_t;

   typedef struct packed {
      share_t s0;
      share_t s1;
   } share2_t;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } q_op_e;

endpackage

// File: rtl/gf16_share_pair_xor.sv
// ----------------------------------------------------------------------------
// gf16_share_pair_xor
//   Pure combinational XOR of two registered shares. Kept as its own module
//   so the share pairing chosen by the parent stays visible at the instance.
//   Ports:
//     q_a, q_b : registered shares to combine (W bits each)
//     q_x      : q_a ^ q_b
// ----------------------------------------------------------------------------
module gf16_share_pair_xor #(
   parameter int W = 4
) (
   input  logic [W-1:0] q_a,
   input  logic [W-1:0] q_b,
   output logic [W-1:0] q_x
);

   assign q_x = q_a ^ q_b;

endmodule

// File: rtl/gf16_share_compress_reg.sv
// ----------------------------------------------------------------------------
// gf16_share_compress_reg
//   Receive side of the 2->4 share-expanding GF(2^4) multiply stage. The four
//   expanded shares are registered (glitch barrier) into a 2-entry elastic
//   queue, and the head entry is compressed back to two shares:
//     out_s0 = q0 ^ q1,  out_s1 = q2 ^ q3
//   The fresh mask r0 cancels inside each pair; r1 survives in both outputs.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     clear               : synchronous flush (queue emptied, storage zeroed)
//     in_valid/in_ready   : input handshake, in_ready = (count != 2)
//     in_q0..in_q3        : expanded shares, 4*LANES bits each
//     out_valid/out_ready : output handshake, out_valid = (count != 0)
//     out_s0, out_s1      : compressed pair of the head entry
//     count               : entries held (0..2)
// ----------------------------------------------------------------------------
module gf16_share_compress_reg
   import gf16_share_compress_reg_pkg::*;
#(
   parameter int LANES = LANES_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SHARE_W*LANES-1:0] in_q0,
   input  logic [SHARE_W*LANES-1:0] in_q1,
   input  logic [SHARE_W*LANES-1:0] in_q2,
   input  logic [SHARE_W*LANES-1:0] in_q3,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SHARE_W*LANES-1:0] out_s0,
   output logic [SHARE_W*LANES-1:0] out_s1,
   output logic [1:0]               count
);

   localparam int W = SHARE_W * LANES;

   // Two slots, each holding four uncompressed shares; index 0 is q0.
   logic [3:0][W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              push;
   logic              pop;
   q_op_e             op;

   // Handshake flags come from the occupancy register only, so no
   // combinational path runs from in_* to out_* or from out_ready to in_ready.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign op        = q_op_e'({push, pop});

   // NOTE: the share storage is reset and cleared like any control flop; the
   // zero state is part of the masking story (no residue of old shares), so
   // it cannot be left to power-up contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (clear) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments let push and pop both see the
         // pre-edge pointers; with count==1 they always address different slots.
         if (push) begin
            mem[wr_ptr] <= {in_q3, in_q2, in_q1, in_q0};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            // Wipe the departing entry so an empty slot never holds old shares.
            mem[rd_ptr] <= '0;
            rd_ptr      <= ~rd_ptr;
         end
         case (op)
            OP_PUSH: count <= count + 2'd1;
            OP_POP:  count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Compression acts on register outputs only; the head slot of an empty
   // queue has been wiped, so the outputs read zero there.
   gf16_share_pair_xor #(.W(W)) u_pair_01 (
      .q_a (mem[rd_ptr][0]),
      .q_b (mem[rd_ptr][1]),
      .q_x (out_s0)
   );

   gf16_share_pair_xor #(.W(W)) u_pair_23 (
      .q_a (mem[rd_ptr][2]),
      .q_b (mem[rd_ptr][3]),
      .q_x (out_s1)
   );

endmodule
